// File: rtl/result_display_pkg.sv
// Shared constants for the result display: default word width, CPU stage codes, segment constants.
package result_display_pkg;
    localparam int DEFAULT_WORD_SIZE = 16;

    localparam logic [2:0] STAGE_FETCH  = 3'd0;
    localparam logic [2:0] STAGE_DECODE = 3'd1;
    localparam logic [2:0] STAGE_EXEC   = 3'd2;
    localparam logic [2:0] STAGE_MEM    = 3'd3;
    localparam logic [2:0] STAGE_WB     = 3'd4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic       POINT_OFF = 1'b1;

    typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/result_display_hex7seg.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decode.
module hex7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end
endmodule

// File: rtl/result_display.sv
// Captures the CPU result/address on entry to write-back and scans them onto a 4-digit
// seven-segment display; segment and digit outputs are registered together.
module result_display
    import result_display_pkg::*;
#(
    parameter int         WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int         SCAN_DIV  = 50000,
    parameter logic [2:0] WB_STAGE  = STAGE_WB
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           stage,
    input  logic [7:0]           mAddr,
    input  logic [WORD_SIZE-1:0] outResult,
    input  logic                 showAddr,
    output logic [7:0]           b2d,
    output logic [3:0]           an,
    output logic [7:0]           leds
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc;
    digit_idx_t    idx;
    logic [15:0]   cap_result;
    logic [7:0]    cap_addr;
    logic [4:0]    cap_cnt;
    logic          point;
    logic [2:0]    stage_q;

    logic          capture;
    logic          scan_tc;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    glyph;
    logic [6:0]    seg_nxt;
    logic          pt_nxt;

    // Only the rising edge into write-back counts, so a held stage captures once.
    assign capture = (stage == WB_STAGE) && (stage_q != WB_STAGE);
    assign scan_tc = (presc == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            cap_result <= '0;
            cap_addr   <= '0;
            cap_cnt    <= '0;
            point      <= 1'b0;
            stage_q    <= '0;
        end else begin
            stage_q <= stage;
            if (scan_tc) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            if (capture) begin
                cap_result <= outResult[15:0];
                cap_addr   <= mAddr;
                cap_cnt    <= cap_cnt + 5'd1;
                point      <= ~point;
            end
        end
    end

    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        if (!showAddr) begin
            nibble = cap_result[4*idx +: 4];
        end else begin
            case (idx)
                2'd0:    nibble = cap_addr[3:0];
                2'd1:    nibble = cap_addr[7:4];
                default: blank  = 1'b1;
            endcase
        end
    end

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (glyph)
    );

    assign seg_nxt = blank ? SEG_BLANK : glyph;
    assign pt_nxt  = (idx == 2'd0 && point) ? 1'b0 : POINT_OFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'hF;
            b2d <= 8'hFF;
        end else begin
            an  <= ~(4'b0001 << idx);
            b2d <= {pt_nxt, seg_nxt};
        end
    end

    assign leds = {stage_q, cap_cnt};

    generate
        if (WORD_SIZE > 16) begin : g_wide
            logic unused_hi;
            assign unused_hi = ^outResult[WORD_SIZE-1:16];
        end
    endgenerate
endmodule
